mux_scan_sequencer: RTL and testbench
=====================================

Name: mux_scan_sequencer

Overview:
Drives the select lines of an N-to-1 multiplexer to step through enabled input channels. Holds each channel for a fixed dwell time, then samples the multiplexer output. Assembles the samples into an N-bit frame and offers it downstream with a valid/ready handshake. Sits directly upstream of the mux select input (sel) and directly downstream of its output (mux_y).

Parameters:
- N, 4, number of mux channels (N >= 2)
- SEL_W, $clog2(N), select width; derived, not overridden
- DWELL, 4, clock cycles each channel is held before sampling (DWELL >= 1)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  launch one scan; sampled only in IDLE
- cont  input  1  continuous mode; relaunch automatically after each frame handoff
- chan_mask  input  N  enabled channels; bit i enables channel i; latched at launch
- mux_y  input  1  output of the driven N-to-1 mux
- sel  output  SEL_W  mux select, registered
- frame  output  N  completed frame; bit i = sample of channel i, 0 if masked
- frame_valid  output  1  frame available
- frame_ready  input  1  downstream accepts frame
- busy  output  1  scan or handoff in progress

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset values: sel=0, frame=0, frame_valid=0, busy=0, state=IDLE, dwell counter=0, accumulator=0.
- Reset mid-operation: at the next edge, all state returns to reset values. Any partial frame is discarded.
- States: IDLE, SCAN, PRESENT.
- IDLE, start=1 and chan_mask!=0:
  - mask_q<=chan_mask; sel<=lowest set bit of chan_mask.
  - cnt<=0; accumulator<=0; busy<=1; go to SCAN.
- IDLE, start=1 and chan_mask==0: ignored; stay in IDLE with busy=0.
- SCAN:
  - sel is held; cnt increments each edge.
  - At the edge where cnt==DWELL-1, mux_y is written into accumulator bit sel.
  - If sel is the highest set bit of mask_q: frame<=accumulator including this sample; frame_valid<=1; go to PRESENT; sel is held.
  - Otherwise: sel<=next set bit above sel; cnt<=0.
- Latency: with K enabled channels, frame_valid is 1 after the (K*DWELL)-th rising edge following the edge that accepted start. The sample for each channel is taken DWELL edges after sel first shows that channel.
- PRESENT:
  - frame and frame_valid are held stable until frame_ready=1 at an edge. At that edge frame_valid<=0.
  - cont=1 and chan_mask!=0: relaunch as in IDLE with the new chan_mask; busy stays 1.
  - Otherwise: go to IDLE; busy<=0.
- frame_ready is ignored outside PRESENT. start is ignored while busy.
- chan_mask changes during SCAN have no effect until the next launch.
- frame retains its last value in IDLE and SCAN; only frame_valid qualifies it.
- Masked channels are never driven on sel, and their frame bits are 0.
- Counter width is $clog2(DWELL+1). sel never exceeds N-1.

Optional Feature:
- MUX_SCAN_PARITY_EN defined:
  - Adds output frame_parity (1 bit) = XOR of all frame bits.
  - Registered in the same edge as frame; reset 0.
  - Held with frame.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. N=4, DWELL=4. Reset, then start with mask=4'b1111, channel inputs ch0..ch3=1,0,1,0 through a behavioural mux model.
   -> sel=0,1,2,3 for 4 cycles each; frame_valid high after edge 16; frame=4'b0101; frame_parity=0 if enabled.
2. mask=4'b1010, ch0..ch3=0,1,0,1.
   -> sel visits only 1 then 3; frame_valid after edge 8; frame=4'b1010.
3. frame_ready held 0 for 10 cycles after frame_valid.
   -> frame and frame_valid stable throughout; ready=1 -> frame_valid=0 and busy=0 on the next edge.
4. cont=1, frame_ready=1, mask=4'b1111.
   -> frames back-to-back; frame_valid pulses 17 cycles apart, one cycle each; sel restarts at 0 after each handoff.
5. reset pulsed on the 6th cycle of a scan.
   -> next edge: sel=0, busy=0, frame_valid=0; a following start yields the correct full frame.
6. start with mask=4'b0000 -> busy stays 0. A second start pulse during SCAN -> no effect on sel sequence or frame timing.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// Steps an N-to-1 mux select through enabled channels, samples mux_y after a dwell,
// and hands the assembled frame downstream. Optional MUX_SCAN_PARITY_EN adds frame_parity.
module mux_scan_sequencer #(
  parameter int N     = 4,
  parameter int DWELL = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cont,
  input  logic [N-1:0]     chan_mask,
  input  logic             mux_y,
  input  logic             frame_ready,
  output logic [SEL_W-1:0] sel,
  output logic [N-1:0]     frame,
  output logic             frame_valid,
  output logic [1:0]       state_dbg,
  output logic             busy
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic             frame_parity
`endif
);

  // Handshake: a frame transfers on any rising edge where frame_valid and frame_ready
  // are both 1; frame and frame_valid do not change while frame_valid=1 and frame_ready=0.

  localparam int CNT_W = $clog2(DWELL + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t             state_q, state_n;
  logic [SEL_W-1:0]   sel_q, sel_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [N-1:0]       mask_q, mask_n;
  logic [N-1:0]       acc_q, acc_n;
  logic [N-1:0]       frame_q, frame_n;
  logic               valid_q, valid_n;
  logic               busy_q, busy_n;
  logic               parity_q, parity_n;

  logic [SEL_W-1:0]   low_sel;
  logic [SEL_W-1:0]   nxt_sel;
  logic               nxt_found;
  logic [N-1:0]       acc_smp;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      acc_q    <= '0;
      frame_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      sel_q    <= sel_n;
      cnt_q    <= cnt_n;
      mask_q   <= mask_n;
      acc_q    <= acc_n;
      frame_q  <= frame_n;
      valid_q  <= valid_n;
      busy_q   <= busy_n;
      parity_q <= parity_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    sel_n     = sel_q;
    cnt_n     = cnt_q;
    mask_n    = mask_q;
    acc_n     = acc_q;
    frame_n   = frame_q;
    valid_n   = valid_q;
    busy_n    = busy_q;
    parity_n  = parity_q;
    low_sel   = '0;
    nxt_sel   = sel_q;
    nxt_found = 1'b0;
    acc_smp   = acc_q;

    // Descending scans so the last hit is the lowest qualifying channel.
    for (int i = N - 1; i >= 0; i--) begin
      if (chan_mask[i]) low_sel = SEL_W'(i);
      if (mask_q[i] && (i > int'(sel_q))) begin
        nxt_sel   = SEL_W'(i);
        nxt_found = 1'b1;
      end
    end
    acc_smp[sel_q] = mux_y;

    case (state_q)
      IDLE: begin
        if (start && (chan_mask != '0)) begin
          mask_n  = chan_mask;
          sel_n   = low_sel;
          cnt_n   = '0;
          acc_n   = '0;
          busy_n  = 1'b1;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (cnt_q == CNT_W'(DWELL - 1)) begin
          acc_n = acc_smp;
          cnt_n = '0;
          if (!nxt_found) begin
            frame_n  = acc_smp;
            parity_n = ^acc_smp;
            valid_n  = 1'b1;
            state_n  = PRESENT;
          end else begin
            sel_n = nxt_sel;
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      PRESENT: begin
        if (frame_ready) begin
          valid_n = 1'b0;
          // Continuous mode relaunches on the handoff edge with the live mask.
          if (cont && (chan_mask != '0)) begin
            mask_n  = chan_mask;
            sel_n   = low_sel;
            cnt_n   = '0;
            acc_n   = '0;
            busy_n  = 1'b1;
            state_n = SCAN;
          end else begin
            busy_n  = 1'b0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        valid_n = 1'b0;
      end
    endcase
  end

  assign sel         = sel_q;
  assign frame       = frame_q;
  assign frame_valid = valid_q;
  assign busy        = busy_q;
  assign state_dbg   = state_q;

`ifdef MUX_SCAN_PARITY_EN
  assign frame_parity = parity_q;
`else
  logic parity_unused;
  assign parity_unused = parity_q ^ parity_n;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer (N=4, DWELL=4) with a behavioural mux on sel.
// Parity checks are active when MUX_SCAN_PARITY_EN is defined.
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic [3:0] chan_mask = 4'b0000;
  logic       frame_ready = 1'b0;
  logic [3:0] ch = 4'b0000;
  logic       mux_y;
  logic [1:0] sel;
  logic [3:0] frame;
  logic       frame_valid;
  logic [1:0] state_dbg;
  logic       busy;
`ifdef MUX_SCAN_PARITY_EN
  logic       frame_parity;
`endif

  int errors = 0;
  int checks = 0;

  assign mux_y = ch[sel];

  always #5 clk = ~clk;

  mux_scan_sequencer #(.N(4), .DWELL(4)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .cont(cont),
    .chan_mask(chan_mask),
    .mux_y(mux_y),
    .frame_ready(frame_ready),
    .sel(sel),
    .frame(frame),
    .frame_valid(frame_valid),
    .state_dbg(state_dbg),
    .busy(busy)
`ifdef MUX_SCAN_PARITY_EN
    ,
    .frame_parity(frame_parity)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_parity(input string tag, input logic exp);
`ifdef MUX_SCAN_PARITY_EN
    check(tag, frame_parity, exp);
`endif
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!frame_valid && n < budget) begin
      tick();
      n++;
    end
    check("wait_valid", frame_valid, 1);
  endtask

  task automatic handoff(input string tag);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    check({tag, "_ho_valid"}, frame_valid, 0);
    check({tag, "_ho_busy"}, busy, 0);
    check({tag, "_ho_state"}, state_dbg, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_sel", sel, 0);
    check("rst_frame", frame, 0);
    check("rst_valid", frame_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, 0);

    // Test 1: all channels, ch0..ch3 = 1,0,1,0
    ch = 4'b0101;
    chan_mask = 4'b1111;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_sel0", sel, 0);
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e < 16) begin
        check("t1_sel", sel, e / 4);
        check("t1_valid_lo", frame_valid, 0);
      end
    end
    check("t1_valid", frame_valid, 1);
    check("t1_frame", frame, 4'b0101);
    check("t1_sel_hold", sel, 3);
    check_parity("t1_parity", 1'b0);
    handoff("t1");

    // Tests 2/3: sparse mask, then backpressure for 10 cycles
    ch = 4'b1010;
    chan_mask = 4'b1010;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t2_sel0", sel, 1);
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e < 8) begin
        check("t2_sel", sel, (e < 4) ? 1 : 3);
        check("t2_valid_lo", frame_valid, 0);
      end
    end
    check("t2_valid", frame_valid, 1);
    check("t2_frame", frame, 4'b1010);
    check_parity("t2_parity", 1'b0);
    ch = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t3_valid_hold", frame_valid, 1);
      check("t3_frame_hold", frame, 4'b1010);
      check("t3_busy_hold", busy, 1);
    end
    handoff("t3");
    check("t3_frame_retain", frame, 4'b1010);

    // Test 4: continuous mode, back-to-back frames
    ch = 4'b0111;
    chan_mask = 4'b1111;
    cont = 1'b1;
    frame_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 52; e++) begin
      tick();
      check("t4_valid", frame_valid, (e == 16 || e == 33 || e == 50) ? 1 : 0);
      check("t4_busy", busy, 1);
      if (e == 16 || e == 33 || e == 50) begin
        check("t4_frame", frame, 4'b0111);
        check("t4_sel_last", sel, 3);
        check_parity("t4_parity", 1'b1);
      end
      if (e == 17 || e == 34 || e == 51) check("t4_sel_restart", sel, 0);
    end
    cont = 1'b0;
    frame_ready = 1'b0;
    wait_valid(40);
    check("t4_last_frame", frame, 4'b0111);
    handoff("t4");

    // Test 5: reset on the 6th cycle of a scan
    ch = 4'b1001;
    chan_mask = 4'b1111;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 5; e++) tick();
    check("t5_pre_sel", sel, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_sel", sel, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_valid", frame_valid, 0);
    check("t5_rst_frame", frame, 0);
    check("t5_rst_state", state_dbg, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 15; e++) tick();
    check("t5_valid_lo", frame_valid, 0);
    tick();
    check("t5_valid", frame_valid, 1);
    check("t5_frame", frame, 4'b1001);
    check_parity("t5_parity", 1'b0);
    handoff("t5");

    // Test 6: empty mask ignored; start and mask changes during SCAN ignored
    chan_mask = 4'b0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_empty_busy", busy, 0);
    check("t6_empty_state", state_dbg, 0);
    tick();
    check("t6_empty_busy2", busy, 0);
    ch = 4'b1110;
    chan_mask = 4'b0101;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_sel0", sel, 0);
    for (int e = 1; e <= 8; e++) begin
      if (e == 4) begin
        start = 1'b1;
        chan_mask = 4'b1111;
      end else begin
        start = 1'b0;
      end
      tick();
      if (e < 8) begin
        check("t6_sel", sel, (e < 4) ? 0 : 2);
        check("t6_valid_lo", frame_valid, 0);
      end
    end
    start = 1'b0;
    check("t6_valid", frame_valid, 1);
    check("t6_frame", frame, 4'b0100);
    check_parity("t6_parity", 1'b1);
    handoff("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
